// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, optional even parity, 1 stop bit) with a small byte FIFO.
// Error flags are sticky until err_clr. A line held low raises a single frame_err.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT    = 868,
    parameter bit          PARITY_EN       = 1'b0,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk_in,
    input  logic       rstn_in,
    input  logic       rx_in,
    input  logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       busy
);

    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW  = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;

    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PtrW-1:0] FullXor = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e          state;
    logic            rx_m;
    logic            rx_s;
    logic [CntW-1:0] cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            par_pend;

    logic [7:0]      mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;

    logic expiry;
    logic stop_sample;
    logic byte_ok;
    logic set_fe;
    logic set_pe;
    logic set_ov;
    logic full;
    logic do_pop;
    logic do_push;

    always_comb begin
        expiry      = (cnt == '0);
        stop_sample = (state == StStop) && expiry;
        byte_ok     = stop_sample && rx_s && !par_pend;
        set_pe      = stop_sample && rx_s && par_pend;
        set_fe      = stop_sample && !rx_s;
        full        = ((wr_ptr ^ rd_ptr) == FullXor);
        do_pop      = rd_valid && rd_ready;
        // A pop in the same cycle frees the slot the write lands in.
        do_push     = byte_ok && (!full || do_pop);
        set_ov      = byte_ok && full && !do_pop;
    end

    assign rd_valid = (wr_ptr != rd_ptr);
    assign rd_data  = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
    assign busy     = (state != StIdle);

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
            state    <= StIdle;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_pend <= 1'b0;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
            unique case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state <= StStart;
                        cnt   <= CntHalf;
                    end
                end
                StStart: begin
                    if (expiry) begin
                        if (rx_s) begin
                            state <= StIdle;
                        end else begin
                            state    <= StData;
                            bit_idx  <= '0;
                            par_pend <= 1'b0;
                            cnt      <= CntFull;
                        end
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StData: begin
                    if (expiry) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        cnt     <= CntFull;
                        if (bit_idx == 3'd7) begin
                            state <= PARITY_EN ? StParity : StStop;
                        end
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StParity: begin
                    if (expiry) begin
                        par_pend <= (rx_s != ^shreg);
                        cnt      <= CntFull;
                        state    <= StStop;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StStop: begin
                    if (expiry) begin
                        cnt   <= CntFull;
                        state <= rx_s ? StIdle : StBreak;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StBreak: begin
                    if (rx_s) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            mem        <= '{default: '0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= shreg;
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            // A new error wins over a simultaneous clear.
            frame_err  <= set_fe | (frame_err & ~err_clr);
            parity_err <= set_pe | (parity_err & ~err_clr);
            overrun    <= set_ov | (overrun & ~err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a plain instance and a parity-enabled instance, driven with
// directed and random frames and compared against a queue-based model.
module tb_uart_rx_fifo;

    localparam int unsigned Cpb   = 16;
    localparam int unsigned Half  = Cpb / 2;
    localparam int unsigned Depth = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       err_clr;
    logic       rx   [2];
    logic       rdy  [2];
    logic       v    [2];
    logic [7:0] d    [2];
    logic       fe   [2];
    logic       pe   [2];
    logic       ov   [2];
    logic       bsy  [2];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT   (Cpb),
        .PARITY_EN      (1'b0),
        .FIFO_DEPTH_LOG2(2)
    ) u_dut (
        .clk_in    (clk),
        .rstn_in   (rstn),
        .rx_in     (rx[0]),
        .rd_ready  (rdy[0]),
        .rd_valid  (v[0]),
        .rd_data   (d[0]),
        .frame_err (fe[0]),
        .parity_err(pe[0]),
        .overrun   (ov[0]),
        .err_clr   (err_clr),
        .busy      (bsy[0])
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT   (Cpb),
        .PARITY_EN      (1'b1),
        .FIFO_DEPTH_LOG2(2)
    ) u_dut_par (
        .clk_in    (clk),
        .rstn_in   (rstn),
        .rx_in     (rx[1]),
        .rd_ready  (rdy[1]),
        .rd_valid  (v[1]),
        .rd_data   (d[1]),
        .frame_err (fe[1]),
        .parity_err(pe[1]),
        .overrun   (ov[1]),
        .err_clr   (err_clr),
        .busy      (bsy[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         m_fe [2];
    bit         m_pe [2];
    bit         m_ov [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qfront(input int u);
        return (u == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int u);
        if (u == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic qpush(input int u, input logic [7:0] b);
        if (u == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    // Frame outcome from the protocol rules: bad stop -> frame error, bad even parity ->
    // parity error, otherwise the byte is queued unless four are already waiting.
    task automatic model_frame(input int u, input logic [7:0] b, input logic pbit,
                               input logic stop);
        bit par_ok;
        par_ok = (u == 0) ? 1'b1 : (pbit == ^b);
        if (!stop) m_fe[u] = 1'b1;
        else if (!par_ok) m_pe[u] = 1'b1;
        else if (qsize(u) < Depth) qpush(u, b);
        else m_ov[u] = 1'b1;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int u = 0; u < 2; u++) begin
            m_fe[u] = 1'b0;
            m_pe[u] = 1'b0;
            m_ov[u] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        for (int u = 0; u < 2; u++) begin
            m_fe[u] = 1'b0;
            m_pe[u] = 1'b0;
            m_ov[u] = 1'b0;
        end
    endtask

    task automatic check_all(input int u, input string tag);
        check({tag, ".valid"}, 32'(v[u]), 32'(qsize(u) > 0));
        if (qsize(u) > 0) check({tag, ".data"}, 32'(d[u]), 32'(qfront(u)));
        check({tag, ".frame_err"}, 32'(fe[u]), 32'(m_fe[u]));
        check({tag, ".parity_err"}, 32'(pe[u]), 32'(m_pe[u]));
        check({tag, ".overrun"}, 32'(ov[u]), 32'(m_ov[u]));
        check({tag, ".busy"}, 32'(bsy[u]), 0);
    endtask

    task automatic drain(input int u, input string tag);
        while (qsize(u) > 0) begin
            check({tag, ".drain_valid"}, 32'(v[u]), 1);
            check({tag, ".drain_data"}, 32'(d[u]), 32'(qfront(u)));
            rdy[u] = 1'b1;
            @(negedge clk);
            rdy[u] = 1'b0;
            qpop(u);
        end
        check({tag, ".drain_empty"}, 32'(v[u]), 0);
    endtask

    // Stop-bit sample lands 2 (sync) + Half (start centring) + (nb-1)*Cpb cycles after
    // the start edge; the byte is visible one cycle later.
    task automatic send_frame(input int u, input logic [7:0] b, input logic pbit,
                              input logic stop, input bit chk_timing);
        logic [10:0] bits;
        int          nb;
        nb   = (u == 1) ? 11 : 10;
        bits = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        if (u == 1) begin
            bits[9]  = pbit;
            bits[10] = stop;
        end else begin
            bits[9] = stop;
        end
        for (int i = 0; i < nb * int'(Cpb); i++) begin
            @(negedge clk);
            rx[u] = bits[i / int'(Cpb)];
            if (chk_timing && i == 2 + int'(Half) + (nb - 1) * int'(Cpb)) begin
                check("timing.valid_before", 32'(v[u]), 0);
                check("timing.busy_before", 32'(bsy[u]), 1);
            end
            if (chk_timing && i == 3 + int'(Half) + (nb - 1) * int'(Cpb)) begin
                check("timing.valid_after", 32'(v[u]), 1);
                check("timing.busy_after", 32'(bsy[u]), 0);
            end
        end
        @(negedge clk);
        rx[u] = 1'b1;
        repeat (4) @(negedge clk);
        model_frame(u, b, pbit, stop);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic       pbit;
        logic       stop;
        int         u;

        rstn    = 1'b0;
        err_clr = 1'b0;
        rx[0]   = 1'b1;
        rx[1]   = 1'b1;
        rdy[0]  = 1'b0;
        rdy[1]  = 1'b0;

        // Reset and long idle.
        do_reset();
        check("reset.rd_data", 32'(d[0]), 0);
        check("reset.rd_data_p", 32'(d[1]), 0);
        repeat (10 * Cpb) @(negedge clk);
        check_all(0, "idle");
        check_all(1, "idle_p");

        // Two bytes, consumer stalled, then drained in order.
        send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'hA3, 1'b0, 1'b1, 1'b0);
        check_all(0, "two_bytes");
        drain(0, "two_bytes");

        // Line stuck low from reset: one frame error, nothing queued.
        rx[0] = 1'b0;
        do_reset();
        repeat (12 * Cpb) @(negedge clk);
        check("stuck.frame_err", 32'(fe[0]), 1);
        check("stuck.busy", 32'(bsy[0]), 1);
        check("stuck.valid", 32'(v[0]), 0);
        clear_errs();
        repeat (8 * Cpb) @(negedge clk);
        check("stuck.no_second_err", 32'(fe[0]), 0);
        check("stuck.still_break", 32'(bsy[0]), 1);
        rx[0] = 1'b1;
        repeat (4) @(negedge clk);
        check_all(0, "stuck_release");
        send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b0);
        check_all(0, "after_break");
        drain(0, "after_break");

        // Short low glitch: START sees high again and gives up.
        @(negedge clk);
        rx[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 3) check("glitch.busy", 32'(bsy[0]), 1);
        end
        rx[0] = 1'b1;
        repeat (2 * Cpb) @(negedge clk);
        check_all(0, "glitch");

        // Overflow: fifth byte dropped with overrun.
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b1, 1'b0);
        check_all(0, "overflow");
        clear_errs();
        check_all(0, "overflow_clr");
        drain(0, "overflow");

        // Even parity on the parity instance.
        send_frame(1, 8'h0F, 1'b1, 1'b1, 1'b0);
        check_all(1, "par_bad");
        send_frame(1, 8'h0F, 1'b0, 1'b1, 1'b0);
        check_all(1, "par_good");
        drain(1, "par_good");
        clear_errs();

        // Random frames on both instances, occasional bad stop/parity, random draining.
        for (int n = 0; n < 40; n++) begin
            u    = int'($urandom_range(0, 1));
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            pbit = (^b) ^ ($urandom_range(0, 5) == 0);
            send_frame(u, b, pbit, stop, 1'b0);
            check_all(u, "rand");
            if ($urandom_range(0, 2) == 0) drain(u, "rand");
            if ($urandom_range(0, 4) == 0) clear_errs();
        end
        drain(0, "final");
        drain(1, "final_p");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
